// File: rtl/pads_pkg.sv
// Shared types and helpers for the pad-ring power sequencer.
package pads_pkg;

    localparam int PADS_SEQ_STATE_W = 3;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RAMP   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_DOWN   = 3'd5
    } pads_seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pads_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module pads_sync2 (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // NOTE: non-blocking assignments keep both stages sampling the pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pads_pwr_seq.sv
// Pad-ring power sequencer: input-buffer settle, OE group ramp, core reset release, teardown.
// Define PADS_SEQ_STAGGER_EN to switch OE groups one slot at a time; otherwise all groups move together.
module pads_pwr_seq
    import pads_pkg::*;
#(
    parameter int N_GRP       = 4,
    parameter int SETTLE_CYC  = 64,
    parameter int STAGGER_CYC = 16,
    parameter int HOLD_CYC    = 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        poc_ok_i,
    input  logic                        shutdown_req_i,
    output logic                        pad_ie_en_o,
    output logic [N_GRP-1:0]            pad_oe_en_o,
    output logic                        core_rstn_o,
    output logic                        ready_o,
    output logic [PADS_SEQ_STATE_W-1:0] state_o
);

    localparam int CNT_W = $clog2(max3(SETTLE_CYC, STAGGER_CYC, HOLD_CYC) + 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] STAGGER_LD = CNT_W'(STAGGER_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             poc_s;
    pads_seq_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ie_q, ie_d;
    logic [N_GRP-1:0] oe_q, oe_d;
    logic             core_q, core_d;
    logic             rdy_q, rdy_d;
    logic             expired;

`ifdef PADS_SEQ_STAGGER_EN
    localparam int IDX_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_GRP - 1);
    logic [IDX_W-1:0] idx_q, idx_d;
`endif

    pads_sync2 u_poc_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (poc_ok_i),
        .q_o    (poc_s)
    );

    // The counter is loaded with the full cycle count on entry; the phase ends on the edge after it reaches 1.
    assign expired = (cnt_q == CNT_ONE);

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
        ie_d    = ie_q;
        oe_d    = oe_q;
        core_d  = core_q;
        rdy_d   = rdy_q;
`ifdef PADS_SEQ_STAGGER_EN
        idx_d   = idx_q;
`endif

        if (state_q != ST_OFF && !poc_s) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            ie_d    = 1'b0;
            oe_d    = '0;
            core_d  = 1'b0;
            rdy_d   = 1'b0;
`ifdef PADS_SEQ_STAGGER_EN
            idx_d   = '0;
`endif
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    if (poc_s && !shutdown_req_i) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LD;
                        ie_d    = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (shutdown_req_i) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                        ie_d    = 1'b0;
                    end else if (expired) begin
                        state_d = ST_RAMP;
                        cnt_d   = STAGGER_LD;
`ifdef PADS_SEQ_STAGGER_EN
                        idx_d   = '0;
                        oe_d[0] = 1'b1;
`else
                        oe_d    = '1;
`endif
                    end
                end
                ST_RAMP: begin
                    if (shutdown_req_i) begin
                        state_d = ST_DOWN;
                        cnt_d   = STAGGER_LD;
                    end else if (expired) begin
`ifdef PADS_SEQ_STAGGER_EN
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_LD;
                        end else begin
                            idx_d       = idx_q + IDX_W'(1);
                            oe_d[idx_d] = 1'b1;
                            cnt_d       = STAGGER_LD;
                        end
`else
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
`endif
                    end
                end
                ST_HOLD: begin
                    if (shutdown_req_i) begin
                        state_d = ST_DOWN;
                        cnt_d   = STAGGER_LD;
                    end else if (expired) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        core_d  = 1'b1;
                        rdy_d   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (shutdown_req_i) begin
                        state_d = ST_DOWN;
                        cnt_d   = STAGGER_LD;
                        core_d  = 1'b0;
                        rdy_d   = 1'b0;
                    end
                end
                ST_DOWN: begin
                    // idx_q already points at the highest enabled group when DOWN is entered.
                    if (expired) begin
`ifdef PADS_SEQ_STAGGER_EN
                        oe_d[idx_q] = 1'b0;
                        if (idx_q == '0) begin
                            state_d = ST_OFF;
                            ie_d    = 1'b0;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                            cnt_d = STAGGER_LD;
                        end
`else
                        oe_d    = '0;
                        state_d = ST_OFF;
                        ie_d    = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    ie_d    = 1'b0;
                    oe_d    = '0;
                    core_d  = 1'b0;
                    rdy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            ie_q    <= 1'b0;
            oe_q    <= '0;
            core_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef PADS_SEQ_STAGGER_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ie_q    <= ie_d;
            oe_q    <= oe_d;
            core_q  <= core_d;
            rdy_q   <= rdy_d;
`ifdef PADS_SEQ_STAGGER_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign pad_ie_en_o = ie_q;
    assign pad_oe_en_o = oe_q;
    assign core_rstn_o = core_q;
    assign ready_o     = rdy_q;
    assign state_o     = state_q;

endmodule
